spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops per SPI input. Legal values are 2 or more.
REQ-002 Parameter MAX_ADDR, default 7'h04: highest writable register address.
REQ-003 clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk; connected to ui_in[0].
REQ-006 copi  input  1  SPI controller-out data, asynchronous; connected to ui_in[1].
REQ-007 ncs  input  1  SPI chip select, active-low, asynchronous; connected to ui_in[2].
REQ-008 en_reg_out_7_0  output  8  register 0x00; output enables for pins 7..0.
REQ-009 en_reg_out_15_8  output  8  register 0x01; output enables for pins 15..8.
REQ-010 en_reg_pwm_7_0  output  8  register 0x02; PWM select for pins 7..0.
REQ-011 en_reg_pwm_15_8  output  8  register 0x03; PWM select for pins 15..8.
REQ-012 pwm_duty_cycle  output  8  register 0x04; shared PWM duty value.

Function
REQ-013 The block SHALL pass sclk, copi and ncs each through SYNC_STAGES flops before any use.
REQ-014 The host SHALL keep the sclk high time and low time each at least 2 clk periods. The block is not required to handle faster sclk.
REQ-015 Transaction format: 16 bits, MSB first, sampled on synchronized sclk rising edges.
 - bit15 is R/W, where 1 = write.
 - bits14:8 are the 7-bit address.
 - bits7:0 are the data.
REQ-016 The FSM SHALL have three states: IDLE, SHIFT, COMMIT.
 - IDLE -> SHIFT when synchronized ncs is sampled low.
 - SHIFT -> COMMIT when synchronized ncs is sampled high.
 - COMMIT -> IDLE unconditionally after 1 cycle.
REQ-017 On entry to SHIFT, the shift register and bit counter SHALL clear to 0.
REQ-018 In SHIFT, each synchronized sclk rising edge SHALL shift copi into the LSB and increment the bit counter.
REQ-019 The bit counter SHALL saturate at 17, meaning "overflow".
REQ-020 In COMMIT, the addressed register SHALL be written with data only if all of these hold: bit count is exactly 16, R/W = 1, and address <= MAX_ADDR.
REQ-021 Any other transaction SHALL be discarded with no register change. This covers reads, short frames, over-long frames and out-of-range addresses.
REQ-022 Commit latency: the register output SHALL change on the 2nd clk edge after the edge on which the synchronized ncs first reads high.
REQ-023 sclk edges while synchronized ncs is high SHALL be ignored, including the cycle on which ncs rises.
REQ-024 A synchronized sclk rising edge and the ncs rise arriving on the same cycle SHALL NOT count as a bit.
REQ-025 Back-to-back frames with ncs high for at least SYNC_STAGES+2 clk cycles SHALL both commit, in order.
REQ-026 Only the addressed register SHALL change on a commit. All outputs SHALL be driven directly from flops.

Reset
REQ-027 While rst_n = 0, all five output registers SHALL be 8'h00.
REQ-028 While rst_n = 0, the FSM SHALL be in IDLE, and the counter and shift register SHALL be 0.
REQ-029 All synchronizer flops SHALL reset to the idle bus levels: sclk 0, copi 0, ncs 1.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction with no write. After release, the block SHALL wait in IDLE for the next ncs fall.

Structure
REQ-031 A shared package spi_peripheral_pkg SHALL hold:
 - the FSM state typedef;
 - the TRANSACTION_BITS = 16 constant;
 - the register address constants ADDR_EN_OUT_7_0 .. ADDR_PWM_DUTY (0x00 .. 0x04).
REQ-032 One sub-module, spi_sync, SHALL implement a single-bit SYNC_STAGES-deep synchronizer, instantiated three times.
REQ-033 Target size: 120-400 lines of RTL.

Verification
REQ-034 Reset check: assert rst_n low mid-frame, then release -> all five outputs read 8'h00 and the frame is not written.
REQ-035 Full sweep: write 0x80 F0, 0x81 0F, 0x82 AA, 0x83 55, 0x84 80 -> registers read F0/0F/AA/55/80 exactly 2 clk edges after each synchronized ncs rise.
REQ-036 Rejected writes, each sent after 0x84 80 -> pwm_duty_cycle stays 0x80:
 - 0x04 33 (read);
 - 0x85 77 (address 5);
 - 15-bit frame;
 - 17-bit frame.
REQ-037 Fastest timing: back-to-back frames 0x82 01 then 0x82 02, with sclk at clk/4 and ncs high 4 cycles -> en_reg_pwm_7_0 reads 01, then 02.
REQ-038 Noise while deselected: 20 sclk toggles with ncs high, then frame 0x80 C3 -> en_reg_out_7_0 = C3 and no other register changes.

Source files
------------

// File: rtl/spi_peripheral_pkg.sv
// Shared types and constants for the SPI register peripheral.
// Frame layout: {rw, addr[6:0], data[7:0]}, MSB first.
package spi_peripheral_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  localparam int TRANSACTION_BITS = 16;
  localparam int CNT_W            = 5;
  // Counter parks here once a frame runs past TRANSACTION_BITS.
  localparam logic [CNT_W-1:0] CNT_OVF = 5'd17;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle: the host drives all three lines, the peripheral only listens.
interface spi_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer; RST_VAL is the idle level of the line.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ff <= {STAGES{RST_VAL}};
    else        r_ff <= {r_ff[STAGES-2:0], i_d};
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI register file: five 8-bit control registers loaded from
// 16-bit frames once chip select is released.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_peripheral_if.slave  spi,
  output logic [7:0]       en_reg_out_7_0,
  output logic [7:0]       en_reg_out_15_8,
  output logic [7:0]       en_reg_pwm_7_0,
  output logic [7:0]       en_reg_pwm_15_8,
  output logic [7:0]       pwm_duty_cycle
);

  logic w_sclk, w_copi, w_ncs;
  logic w_sclk_rise;
  logic r_sclk_q;

  state_t                        r_state;
  logic [TRANSACTION_BITS-1:0]   r_shreg;
  logic [CNT_W-1:0]              r_cnt;

  logic       w_rw;
  logic [6:0] w_addr;
  logic [7:0] w_data;
  logic       w_commit_ok;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(spi.sclk), .o_q(w_sclk));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .i_d(spi.copi), .o_q(w_copi));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .i_d(spi.ncs), .o_q(w_ncs));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sclk_q <= 1'b0;
    else        r_sclk_q <= w_sclk;
  end

  assign w_sclk_rise = w_sclk & ~r_sclk_q;

  assign w_rw        = r_shreg[15];
  assign w_addr      = r_shreg[14:8];
  assign w_data      = r_shreg[7:0];
  assign w_commit_ok = (r_cnt == CNT_W'(TRANSACTION_BITS)) && w_rw && (w_addr <= MAX_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_shreg         <= '0;
      r_cnt           <= '0;
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_ncs) begin
            r_state <= ST_SHIFT;
            r_shreg <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          // Deselect wins over a coincident sclk edge: that edge is not a bit.
          if (w_ncs) begin
            r_state <= ST_COMMIT;
          end else if (w_sclk_rise) begin
            r_shreg <= {r_shreg[TRANSACTION_BITS-2:0], w_copi};
            if (r_cnt != CNT_OVF) r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          if (w_commit_ok) begin
            case (w_addr)
              ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= w_data;
              ADDR_EN_OUT_15_8: en_reg_out_15_8 <= w_data;
              ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= w_data;
              ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= w_data;
              ADDR_PWM_DUTY:    pwm_duty_cycle  <= w_data;
              default: ;
            endcase
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench: frames bit-banged at clk/4, register file compared
// against a five-entry model at fixed cycle offsets from ncs release.
module tb_spi_peripheral;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  spi_peripheral_if bus ();

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi(bus.slave),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] m [5];

  wire [39:0] w_obs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

  function automatic logic [39:0] model_all();
    return {m[4], m[3], m[2], m[1], m[0]};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.copi = b;
    tick(2);
    bus.sclk = 1'b1;
    tick(2);
    bus.sclk = 1'b0;
  endtask

  // Leaves ncs high, just after a rising clk edge.
  task automatic frame(input logic [16:0] bits, input int n);
    bus.ncs = 1'b0;
    tick(2);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    tick(2);
    bus.ncs = 1'b1;
  endtask

  // Synchronized ncs rises 2 edges after release; the write lands 2 edges later.
  task automatic commit_chk(input string tag, input int idx, input logic [7:0] val);
    tick(3);
    chk({tag, "_before"}, w_obs, model_all());
    tick(1);
    m[idx] = val;
    chk({tag, "_after"}, w_obs, model_all());
  endtask

  task automatic reject_chk(input string tag, input logic [16:0] bits, input int n);
    frame(bits, n);
    tick(8);
    chk(tag, w_obs, model_all());
  endtask

  initial begin
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    rst_n    = 1'b0;
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    tick(3);
    chk("reset", w_obs, 40'h0);
    rst_n = 1'b1;
    tick(3);

    frame(17'h080F0, 16); commit_chk("w00", 0, 8'hF0);
    frame(17'h0810F, 16); commit_chk("w01", 1, 8'h0F);
    frame(17'h082AA, 16); commit_chk("w02", 2, 8'hAA);
    frame(17'h08355, 16); commit_chk("w03", 3, 8'h55);
    frame(17'h08480, 16); commit_chk("w04", 4, 8'h80);

    reject_chk("rej_read",  17'h00433, 16);
    reject_chk("rej_addr5", 17'h08577, 16);
    reject_chk("rej_15bit", 17'h04233, 15);
    reject_chk("rej_17bit", 17'h18411, 17);

    // Reset in the middle of a write; the tail after release must not commit.
    bus.ncs = 1'b0;
    tick(2);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h80 >> i));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clear", w_obs, 40'h0);
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hFF >> i));
    tick(2);
    bus.ncs = 1'b1;
    tick(8);
    chk("rst_mid_nowrite", w_obs, model_all());

    // Back-to-back with minimum deselect gap.
    frame(17'h08201, 16);
    tick(4);
    m[2] = 8'h01;
    chk("b2b_first", w_obs, model_all());
    frame(17'h08202, 16);
    commit_chk("b2b_second", 2, 8'h02);

    tick(4);
    for (int i = 0; i < 20; i++) begin
      bus.sclk = ~bus.sclk;
      bus.copi = 1'($urandom_range(0, 1));
      tick(2);
    end
    chk("noise_idle", w_obs, model_all());
    frame(17'h080C3, 16);
    commit_chk("noise_frame", 0, 8'hC3);

    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
